// File: rtl/iz_neuron_array.sv
// Time-multiplexed Izhikevich neuron array: one shared datapath fetches a neuron,
// updates it the next cycle, and publishes spikes/membrane bytes when the step ends.
//   state    | meaning
//   S_IDLE   | waiting for step_start with enable
//   S_FETCH  | latch v/u/params/stimulus of neuron r_idx
//   S_UPDATE | compute and write back neuron r_idx
//   S_DONE   | outputs published, step_done pulse
module iz_neuron_array #(
    parameter  int N_NEURONS  = 4,
    parameter  int DATA_W     = 16,
    parameter  int FRAC_BITS  = 6,
    parameter  int PARAM_FRAC = 12,
    parameter  int STIM_W     = 8,
    parameter  int DT_SHIFT   = 2,
    localparam int IDX_W      = $clog2(N_NEURONS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          step_start,
    output logic                          step_busy,
    output logic                          step_done,
    input  logic [N_NEURONS*STIM_W-1:0]   stimulus_input,
    input  logic                          cfg_we,
    output logic                          cfg_ready,
    input  logic [IDX_W-1:0]              cfg_addr,
    input  logic [1:0]                    cfg_sel,
    input  logic [DATA_W-1:0]             cfg_wdata,
    output logic [N_NEURONS-1:0]          neuron_valid,
    output logic [N_NEURONS-1:0]          spike_vec,
    output logic [N_NEURONS*7-1:0]        membrane_bus,
    input  logic [IDX_W-1:0]              stat_addr,
    output logic [DATA_W-1:0]             stat_v,
    output logic [DATA_W-1:0]             stat_u
);

    localparam int ACC_W = 48;
    localparam logic signed [DATA_W-1:0] V_REST   = DATA_W'(-70 * (2 ** FRAC_BITS));
    localparam logic signed [DATA_W-1:0] V_TH     = DATA_W'(30 * (2 ** FRAC_BITS));
    localparam logic signed [ACC_W-1:0]  V_REST_X = ACC_W'(-70 * (2 ** FRAC_BITS));
    localparam logic signed [ACC_W-1:0]  K_140    = ACC_W'(140 * (2 ** FRAC_BITS));
    localparam logic signed [ACC_W-1:0]  K_41     = ACC_W'(41);
    localparam logic signed [ACC_W-1:0]  K_5      = ACC_W'(5);
    localparam logic signed [ACC_W-1:0]  K_127    = ACC_W'(127);
    localparam logic signed [ACC_W-1:0]  SAT_MAX  = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MIN  = ACC_W'(-(2 ** (DATA_W - 1)));
    localparam logic [IDX_W:0]           N_LIM    = (IDX_W + 1)'(N_NEURONS);
    localparam logic [IDX_W-1:0]         LAST_IDX = IDX_W'(N_NEURONS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_UPDATE, S_DONE} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               w_busy, w_done, w_do_fetch, w_do_update, w_last;

    logic [DATA_W-1:0]  r_v  [N_NEURONS];
    logic [DATA_W-1:0]  r_u  [N_NEURONS];
    logic [DATA_W-1:0]  r_pa [N_NEURONS];
    logic [DATA_W-1:0]  r_pb [N_NEURONS];
    logic [DATA_W-1:0]  r_pc [N_NEURONS];
    logic [DATA_W-1:0]  r_pd [N_NEURONS];
    logic [3:0]         r_seen [N_NEURONS];

    logic [DATA_W-1:0]  r_f_v, r_f_u, r_f_a, r_f_b, r_f_c, r_f_d;
    logic [STIM_W-1:0]  r_f_i;
    logic               r_f_valid;

    logic [N_NEURONS-1:0]   r_stg_spk, r_spike_vec, w_stg_spk_nxt;
    logic [N_NEURONS*7-1:0] r_stg_mem, r_membrane, w_stg_mem_nxt;
    logic [DATA_W-1:0]      r_stat_v, r_stat_u;

    logic signed [ACC_W-1:0] w_v, w_u, w_a, w_b, w_c, w_d, w_i;
    logic signed [ACC_W-1:0] w_sq, w_dv, w_vn_raw, w_bv, w_du, w_un_raw, w_vn_x, w_mem_raw;
    logic [DATA_W-1:0]       w_v_new, w_u_new;
    logic                    w_spk, w_cfg_hit;
    logic [6:0]              w_mem;

    function automatic logic [DATA_W-1:0] sat(input logic signed [ACC_W-1:0] x);
        if (x > SAT_MAX)      sat = SAT_MAX[DATA_W-1:0];
        else if (x < SAT_MIN) sat = SAT_MIN[DATA_W-1:0];
        else                  sat = x[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (step_start && enable) begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH:  w_state_nxt = S_UPDATE;
            S_UPDATE: begin
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_FETCH;
                    w_idx_nxt   = r_idx + IDX_W'(1);
                end
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy      = (r_state == S_FETCH) || (r_state == S_UPDATE);
        w_done      = (r_state == S_DONE);
        w_do_fetch  = (r_state == S_FETCH);
        w_do_update = (r_state == S_UPDATE);
        w_last      = w_do_update && (r_idx == LAST_IDX);
    end

    assign step_busy    = w_busy;
    assign step_done    = w_done;
    assign cfg_ready    = !w_busy;
    assign spike_vec    = r_spike_vec;
    assign membrane_bus = r_membrane;
    assign stat_v       = r_stat_v;
    assign stat_u       = r_stat_u;
    assign w_cfg_hit    = cfg_we && !w_busy && ({1'b0, cfg_addr} < N_LIM);

    always_comb begin
        neuron_valid = '0;
        for (int k = 0; k < N_NEURONS; k++) neuron_valid[k] = &r_seen[k];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                r_v[k]    <= V_REST;
                r_u[k]    <= '0;
                r_pa[k]   <= '0;
                r_pb[k]   <= '0;
                r_pc[k]   <= '0;
                r_pd[k]   <= '0;
                r_seen[k] <= '0;
            end
        end else begin
            if (w_cfg_hit) begin
                case (cfg_sel)
                    2'd0: r_pa[cfg_addr] <= cfg_wdata;
                    2'd1: r_pb[cfg_addr] <= cfg_wdata;
                    2'd2: r_pc[cfg_addr] <= cfg_wdata;
                    2'd3: r_pd[cfg_addr] <= cfg_wdata;
                endcase
                r_seen[cfg_addr][cfg_sel] <= 1'b1;
            end
            if (w_do_update && r_f_valid) begin
                r_v[r_idx] <= w_v_new;
                r_u[r_idx] <= w_u_new;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_f_v     <= '0;
            r_f_u     <= '0;
            r_f_a     <= '0;
            r_f_b     <= '0;
            r_f_c     <= '0;
            r_f_d     <= '0;
            r_f_i     <= '0;
            r_f_valid <= 1'b0;
        end else if (w_do_fetch) begin
            r_f_v     <= r_v[r_idx];
            r_f_u     <= r_u[r_idx];
            r_f_a     <= r_pa[r_idx];
            r_f_b     <= r_pb[r_idx];
            r_f_c     <= r_pc[r_idx];
            r_f_d     <= r_pd[r_idx];
            r_f_i     <= stimulus_input[r_idx*STIM_W +: STIM_W];
            r_f_valid <= &r_seen[r_idx];
        end
    end

    // a, b and stimulus are unsigned; v, u, c, d are signed
    always_comb begin
        w_v = {{(ACC_W-DATA_W){r_f_v[DATA_W-1]}}, r_f_v};
        w_u = {{(ACC_W-DATA_W){r_f_u[DATA_W-1]}}, r_f_u};
        w_c = {{(ACC_W-DATA_W){r_f_c[DATA_W-1]}}, r_f_c};
        w_d = {{(ACC_W-DATA_W){r_f_d[DATA_W-1]}}, r_f_d};
        w_a = {{(ACC_W-DATA_W){1'b0}}, r_f_a};
        w_b = {{(ACC_W-DATA_W){1'b0}}, r_f_b};
        w_i = {{(ACC_W-STIM_W){1'b0}}, r_f_i};

        w_sq     = (w_v * w_v * K_41) >>> (FRAC_BITS + 10);
        w_dv     = w_sq + (w_v * K_5) + K_140 - w_u + (w_i <<< FRAC_BITS);
        w_vn_raw = w_v + (w_dv >>> DT_SHIFT);
        w_bv     = (w_b * w_v) >>> PARAM_FRAC;
        w_du     = (w_a * (w_bv - w_u)) >>> PARAM_FRAC;
        w_un_raw = w_u + (w_du >>> DT_SHIFT);

        w_v_new   = r_f_v;
        w_u_new   = r_f_u;
        w_spk     = 1'b0;
        w_mem     = '0;
        w_vn_x    = '0;
        w_mem_raw = '0;
        if (r_f_valid) begin
            if ($signed(r_f_v) >= V_TH) begin
                w_v_new = r_f_c;
                w_u_new = sat(w_u + w_d);
                w_spk   = 1'b1;
                w_mem   = 7'd127;
            end else begin
                w_v_new   = sat(w_vn_raw);
                w_u_new   = sat(w_un_raw);
                w_vn_x    = {{(ACC_W-DATA_W){w_v_new[DATA_W-1]}}, w_v_new};
                w_mem_raw = (w_vn_x - V_REST_X) >>> FRAC_BITS;
                if (w_mem_raw < 0)          w_mem = '0;
                else if (w_mem_raw > K_127) w_mem = 7'd127;
                else                        w_mem = w_mem_raw[6:0];
            end
        end

        w_stg_spk_nxt                 = r_stg_spk;
        w_stg_spk_nxt[r_idx]          = w_spk;
        w_stg_mem_nxt                 = r_stg_mem;
        w_stg_mem_nxt[r_idx*7 +: 7]   = w_mem;
    end

    // the last neuron's result is merged in so every output bit changes on the same edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stg_spk   <= '0;
            r_stg_mem   <= '0;
            r_spike_vec <= '0;
            r_membrane  <= '0;
        end else if (w_do_update) begin
            r_stg_spk <= w_stg_spk_nxt;
            r_stg_mem <= w_stg_mem_nxt;
            if (w_last) begin
                r_spike_vec <= w_stg_spk_nxt;
                r_membrane  <= w_stg_mem_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stat_v <= '0;
            r_stat_u <= '0;
        end else if ({1'b0, stat_addr} < N_LIM) begin
            r_stat_v <= r_v[stat_addr];
            r_stat_u <= r_u[stat_addr];
        end else begin
            r_stat_v <= '0;
            r_stat_u <= '0;
        end
    end

endmodule

// File: tb/tb_iz_neuron_array.sv
// Directed bench for iz_neuron_array: table of single-step vectors for neuron 0
// plus hand-written sequences for busy handling, back-to-back steps, saturation and reset.
module tb_iz_neuron_array;

    logic               clk = 1'b0;
    logic               reset_n, enable, step_start, step_busy, step_done;
    logic [31:0]        stimulus_input;
    logic               cfg_we, cfg_ready;
    logic [1:0]         cfg_addr, cfg_sel, stat_addr;
    logic [15:0]        cfg_wdata;
    logic [3:0]         neuron_valid, spike_vec;
    logic [27:0]        membrane_bus;
    logic signed [15:0] stat_v, stat_u;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit rst;
        int stim;
        int v;
        int u;
        int mem;
        int spk;
    } vec_t;
    vec_t tbl [5];

    iz_neuron_array dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .step_start(step_start),
        .step_busy(step_busy), .step_done(step_done), .stimulus_input(stimulus_input),
        .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr), .cfg_sel(cfg_sel),
        .cfg_wdata(cfg_wdata), .neuron_valid(neuron_valid), .spike_vec(spike_vec),
        .membrane_bus(membrane_bus), .stat_addr(stat_addr), .stat_v(stat_v), .stat_u(stat_u)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic cfg_write(input int addr, input int sel, input int data);
        cfg_we    = 1'b1;
        cfg_addr  = 2'(addr);
        cfg_sel   = 2'(sel);
        cfg_wdata = 16'(data);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic config_n0(input int c, input int d);
        cfg_write(0, 0, 82);
        cfg_write(0, 1, 819);
        cfg_write(0, 2, c);
        cfg_write(0, 3, d);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        tick();
    endtask

    task automatic run_step(output int cyc);
        enable     = 1'b1;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        cyc = 1;
        while (step_done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, first, second, ndone;
        int exp_v6 [5];
        int exp_u6 [5];
        int exp_s6 [5];

        reset_n = 1'b0; enable = 1'b0; step_start = 1'b0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_sel = '0; cfg_wdata = '0; stimulus_input = '0; stat_addr = '0;

        tbl[0] = '{1'b1,   0, -4701,  -5,   0, 0};
        tbl[1] = '{1'b1, 255,  -621,  -5,  60, 0};
        tbl[2] = '{1'b0, 255,  4984,  -6, 127, 0};
        tbl[3] = '{1'b0, 255, -4160, 506, 127, 1};
        tbl[4] = '{1'b0,   0, -4540, 499,   0, 0};

        exp_v6 = '{-621, 4984, 1920, 1920, 1920};
        exp_u6 = '{-5, -6, 32761, 32767, 32767};
        exp_s6 = '{0, 0, 1, 1, 1};

        tick();
        tick();
        check("rst_stat_v_held", int'(stat_v), 0);
        check("rst_busy_held", int'(step_busy), 0);
        reset_n = 1'b1;
        tick();
        check("rst_membrane", int'(membrane_bus), 0);
        check("rst_spike", int'(spike_vec), 0);
        check("rst_stat_v", int'(stat_v), -4480);
        check("rst_stat_u", int'(stat_u), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        check("rst_valid", int'(neuron_valid), 0);

        for (int i = 0; i < 5; i++) begin
            if (tbl[i].rst) begin
                do_reset();
                config_n0(-4160, 512);
            end
            stimulus_input      = '0;
            stimulus_input[7:0] = 8'(tbl[i].stim);
            run_step(cyc);
            check($sformatf("vec%0d_latency", i), cyc, 9);
            check($sformatf("vec%0d_busy_at_done", i), int'(step_busy), 0);
            check($sformatf("vec%0d_spike", i), int'(spike_vec[0]), tbl[i].spk);
            check($sformatf("vec%0d_membrane", i), int'(membrane_bus[6:0]), tbl[i].mem);
            tick();
            check($sformatf("vec%0d_v", i), int'(stat_v), tbl[i].v);
            check($sformatf("vec%0d_u", i), int'(stat_u), tbl[i].u);
        end

        check("unconf_valid", int'(neuron_valid), 1);
        stat_addr = 2'd1;
        tick();
        check("unconf_v", int'(stat_v), -4480);
        check("unconf_u", int'(stat_u), 0);
        check("unconf_membrane", int'(membrane_bus[13:7]), 0);
        check("unconf_spike", int'(spike_vec[1]), 0);
        stat_addr = 2'd0;

        first = 0;
        second = 0;
        enable = 1'b1;
        step_start = 1'b1;
        tick();
        for (int c = 1; c <= 30; c++) begin
            if (step_done === 1'b1) begin
                if (first == 0) first = c;
                else if (second == 0) second = c;
            end
            if (c == 10) check("b2b_busy_after_done", int'(step_busy), 1);
            tick();
        end
        step_start = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        check("b2b_first_done", first, 9);
        check("b2b_second_done", second, 18);

        do_reset();
        config_n0(-4160, 512);
        stimulus_input = '0;
        ndone = 0;
        enable = 1'b1;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            if (c == 2) begin
                check("busy_cfg_ready", int'(cfg_ready), 0);
                check("busy_flag", int'(step_busy), 1);
            end
            if (c == 9) check("enable_low_done", int'(step_done), 1);
            if (step_done === 1'b1) ndone++;
            cfg_we     = (c >= 2 && c <= 5);
            cfg_addr   = 2'd2;
            cfg_sel    = 2'(c - 2);
            cfg_wdata  = 16'd100;
            step_start = (c == 3);
            enable     = (c < 4);
            tick();
        end
        cfg_we = 1'b0;
        step_start = 1'b0;
        enable = 1'b1;
        check("busy_done_count", ndone, 1);
        check("busy_cfg_dropped", int'(neuron_valid), 1);
        check("busy_single_step_v", int'(stat_v), -4701);
        check("busy_single_step_u", int'(stat_u), -5);

        do_reset();
        config_n0(1920, 32767);
        stimulus_input = 32'h0000_00FF;
        for (int s = 0; s < 5; s++) begin
            run_step(cyc);
            check($sformatf("sat%0d_latency", s), cyc, 9);
            check($sformatf("sat%0d_spike", s), int'(spike_vec[0]), exp_s6[s]);
            tick();
            check($sformatf("sat%0d_v", s), int'(stat_v), exp_v6[s]);
            check($sformatf("sat%0d_u", s), int'(stat_u), exp_u6[s]);
        end

        enable = 1'b1;
        step_start = 1'b1;
        tick();
        step_start = 1'b0;
        tick();
        tick();
        check("midrst_busy_before", int'(step_busy), 1);
        reset_n = 1'b0;
        #1;
        check("midrst_busy", int'(step_busy), 0);
        check("midrst_done", int'(step_done), 0);
        check("midrst_stat_v", int'(stat_v), 0);
        check("midrst_spike", int'(spike_vec), 0);
        check("midrst_membrane", int'(membrane_bus), 0);
        tick();
        tick();
        reset_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (step_done === 1'b1) ndone++;
        end
        check("midrst_no_done", ndone, 0);
        check("midrst_v_rest", int'(stat_v), -4480);
        check("midrst_u_zero", int'(stat_u), 0);
        check("midrst_valid", int'(neuron_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
